// File: rtl/uart_pkg.sv
// Shared constants for the UART time-stamp generator: stamp widths, counter limits
// and the packing helper for the 48-bit snapshot word.
package uart_pkg;

  localparam int unsigned ACQ_W   = 4;
  localparam int unsigned MS_W    = 12;
  localparam int unsigned SEC_W   = 32;
  localparam int unsigned SNAP_W  = 48;
  localparam int unsigned PRESC_W = 16;

  localparam int unsigned TICK_DIV_DEF  = 4000;
  localparam int unsigned SUBMS_MAX_DEF = 9;
  localparam int unsigned MS_MAX_DEF    = 999;

  // PPS alignment rounds up to the next second from this millisecond onwards
  localparam int unsigned MS_ROUND = 500;

  function automatic logic [SNAP_W-1:0] pack_stamp(input logic [SEC_W-1:0] sec,
                                                   input logic [MS_W-1:0]  ms,
                                                   input logic [ACQ_W-1:0] acq);
    return {sec, ms, acq};
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector. o_rise is high for one
// cycle, two edges after the asynchronous input rises; the consumer acts on the third.
module uart_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/uart_time_stamp_gen.sv
// Free-running 100us / ms / s time base for the UART core's receive time stamps.
// Includes bus load, enable and snapshot. Optional PPS alignment is built when the
// macro TIMESTAMP_PPS_SYNC_EN is defined; otherwise Pps_i is ignored.
module uart_time_stamp_gen
  import uart_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned SUBMS_MAX = SUBMS_MAX_DEF,
  parameter int unsigned MS_MAX    = MS_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_Enable_i,
  input  logic              p_Load_i,
  input  logic [SEC_W-1:0]  SecondLoad_i,
  input  logic              p_Snap_i,
  input  logic              Pps_i,
  output logic [ACQ_W-1:0]  acqurate_stamp_o,
  output logic [MS_W-1:0]   millisecond_stamp_o,
  output logic [SEC_W-1:0]  second_stamp_o,
  output logic [SNAP_W-1:0] SnapStamp_o,
  output logic              p_Tick_o,
  output logic              p_SecPulse_o
);

  localparam logic [PRESC_W-1:0] LP_PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [ACQ_W-1:0]   LP_ACQ_MAX   = ACQ_W'(SUBMS_MAX);
  localparam logic [MS_W-1:0]    LP_MS_MAX    = MS_W'(MS_MAX);
  localparam logic [MS_W-1:0]    LP_MS_ROUND  = MS_W'(MS_ROUND);

  logic [PRESC_W-1:0] r_presc;
  logic               r_tick;
  logic [ACQ_W-1:0]   r_acq;
  logic [MS_W-1:0]    r_ms;
  logic [SEC_W-1:0]   r_sec;
  logic               r_sec_pulse;
  logic [SNAP_W-1:0]  r_snap;

  logic w_pps_edge;
  logic w_clear;
  logic w_adv;
  logic w_acq_wrap;
  logic w_ms_wrap;
  logic w_presc_wrap;

`ifdef TIMESTAMP_PPS_SYNC_EN
  logic w_pps_rise;

  uart_sync_edge u_pps_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (Pps_i),
    .o_rise  (w_pps_rise)
  );

  assign w_pps_edge = w_pps_rise & p_Enable_i;
`else
  // Port kept so the core wiring is identical in both builds
  logic w_unused_pps;
  assign w_unused_pps = Pps_i;
  assign w_pps_edge   = 1'b0;
`endif

  // Shared cascade controls; a load or PPS edge both restart the sub-second chain
  always_comb begin
    w_clear      = p_Load_i | w_pps_edge;
    w_adv        = r_tick & p_Enable_i;
    w_acq_wrap   = (r_acq == LP_ACQ_MAX);
    w_ms_wrap    = (r_ms == LP_MS_MAX);
    w_presc_wrap = (r_presc == LP_PRESC_MAX);
  end

  // Prescaler: 0..TICK_DIV-1 while enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_clear) begin
      r_presc <= '0;
    end else if (p_Enable_i) begin
      r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
    end
  end

  // Registered 100us tick; the cascade below advances on it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= p_Enable_i & ~w_clear & w_presc_wrap;
    end
  end

  // 100us stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acq <= '0;
    end else if (w_clear) begin
      r_acq <= '0;
    end else if (w_adv) begin
      r_acq <= w_acq_wrap ? '0 : r_acq + 1'b1;
    end
  end

  // Millisecond stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ms <= '0;
    end else if (w_clear) begin
      r_ms <= '0;
    end else if (w_adv && w_acq_wrap) begin
      r_ms <= w_ms_wrap ? '0 : r_ms + 1'b1;
    end
  end

  // Seconds stage: load beats PPS beats the normal carry; wraps modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec       <= '0;
      r_sec_pulse <= 1'b0;
    end else if (p_Load_i) begin
      r_sec       <= SecondLoad_i;
      r_sec_pulse <= 1'b0;
    end else if (w_pps_edge) begin
      if (r_ms >= LP_MS_ROUND) begin
        r_sec       <= r_sec + 1'b1;
        r_sec_pulse <= 1'b1;
      end else begin
        r_sec_pulse <= 1'b0;
      end
    end else if (w_adv && w_acq_wrap && w_ms_wrap) begin
      r_sec       <= r_sec + 1'b1;
      r_sec_pulse <= 1'b1;
    end else begin
      r_sec_pulse <= 1'b0;
    end
  end

  // Snapshot takes the pre-edge stamp, so a simultaneous load is not seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
    end else if (p_Snap_i) begin
      r_snap <= pack_stamp(r_sec, r_ms, r_acq);
    end
  end

  assign acqurate_stamp_o    = r_acq;
  assign millisecond_stamp_o = r_ms;
  assign second_stamp_o      = r_sec;
  assign SnapStamp_o         = r_snap;
  assign p_Tick_o            = r_tick;
  assign p_SecPulse_o        = r_sec_pulse;

endmodule
